// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port and single-ported memory side.
// The slave modport is the arbiter's view; master is the view of whatever drives the requests and memory data.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one single-cycle memory.
// Ties alternate between ports; a read's data returns to its owner one cycle after the grant.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    owner_t lastOwner;
    owner_t rdOwner;
    logic   rdPending;
    logic   iGnt;
    logic   dGnt;
    logic   unusedAddrLsbs;

    // Grants are combinational and forced low while reset is held.
    always_comb begin
        iGnt = 1'b0;
        dGnt = 1'b0;
        if (!reset) begin
            if (bus.i_req && bus.d_req) begin
                iGnt = (lastOwner == OWN_DATA);
                dGnt = (lastOwner == OWN_INSTR);
            end else begin
                iGnt = bus.i_req;
                dGnt = bus.d_req;
            end
        end
    end

    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (iGnt) begin
            bus.m_en    = 1'b1;
            bus.m_addr  = bus.i_addr[31:2];
            bus.m_wdata = bus.d_wdata;
        end else if (dGnt) begin
            bus.m_en    = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr[31:2];
            bus.m_wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastOwner <= OWN_DATA;
            rdOwner   <= OWN_INSTR;
            rdPending <= 1'b0;
        end else begin
            if (iGnt || dGnt) begin
                lastOwner <= dGnt ? OWN_DATA : OWN_INSTR;
                rdOwner   <= dGnt ? OWN_DATA : OWN_INSTR;
            end
            rdPending <= iGnt || (dGnt && !bus.d_we);
        end
    end

    // rvalid is masked during reset so a read granted just before reset never returns.
    assign bus.i_rvalid = !reset && rdPending && (rdOwner == OWN_INSTR);
    assign bus.d_rvalid = !reset && rdPending && (rdOwner == OWN_DATA);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
    assign bus.i_gnt    = iGnt;
    assign bus.d_gnt    = dGnt;

    assign unusedAddrLsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small behavioural memory answers reads one cycle late,
// and each step compares DUT outputs against hand-computed constants.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sixteen-word memory, reloaded with known contents whenever reset is held.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 16; k++) mem[k] <= '0;
            mem[1] <= 32'h0010_0093;
            mem[4] <= 32'h0000_00A0;
            mem[5] <= 32'h0000_00B0;
            bus.m_rdata <= '0;
        end else if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr[3:0]] <= bus.m_wdata;
            else          bus.m_rdata <= mem[bus.m_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleReqs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic chkAllQuiet(input string tag);
        chk({tag, "_i_gnt"},    32'(bus.i_gnt),    32'd0);
        chk({tag, "_d_gnt"},    32'(bus.d_gnt),    32'd0);
        chk({tag, "_i_rvalid"}, 32'(bus.i_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
        chk({tag, "_m_en"},     32'(bus.m_en),     32'd0);
        chk({tag, "_m_we"},     32'(bus.m_we),     32'd0);
        chk({tag, "_m_addr"},   32'(bus.m_addr),   32'd0);
        chk({tag, "_m_wdata"},  bus.m_wdata,       32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with both ports requesting: everything must stay low.
        reset       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_0010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0014;
        bus.d_wdata = 32'h1234_5678;
        tick();
        @(negedge clk);
        chkAllQuiet("rst");

        // Tie right after reset: I, D, I, D with rvalid one cycle behind each grant.
        tick();
        reset       = 1'b0;
        bus.d_we    = 1'b0;
        @(negedge clk);
        chk("tie1_i_gnt",  32'(bus.i_gnt),  32'd1);
        chk("tie1_d_gnt",  32'(bus.d_gnt),  32'd0);
        chk("tie1_m_addr", 32'(bus.m_addr), 32'd4);
        tick();
        @(negedge clk);
        chk("tie2_d_gnt",    32'(bus.d_gnt),    32'd1);
        chk("tie2_i_gnt",    32'(bus.i_gnt),    32'd0);
        chk("tie2_m_addr",   32'(bus.m_addr),   32'd5);
        chk("tie2_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("tie2_i_rdata",  bus.i_rdata,       32'h0000_00A0);
        tick();
        @(negedge clk);
        chk("tie3_i_gnt",    32'(bus.i_gnt),    32'd1);
        chk("tie3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("tie3_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("tie3_d_rdata",  bus.d_rdata,       32'h0000_00B0);
        tick();
        @(negedge clk);
        chk("tie4_d_gnt",    32'(bus.d_gnt),    32'd1);
        chk("tie4_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("tie4_i_rdata",  bus.i_rdata,       32'h0000_00A0);
        tick();
        idleReqs();
        @(negedge clk);
        chk("tie5_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("tie5_d_rdata",  bus.d_rdata,       32'h0000_00B0);
        chk("tie5_m_en",     32'(bus.m_en),     32'd0);

        // Single instruction fetch.
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0004;
        @(negedge clk);
        chk("fetch_i_gnt",  32'(bus.i_gnt),  32'd1);
        chk("fetch_m_addr", 32'(bus.m_addr), 32'd1);
        chk("fetch_m_en",   32'(bus.m_en),   32'd1);
        chk("fetch_m_we",   32'(bus.m_we),   32'd0);
        tick();
        idleReqs();
        @(negedge clk);
        chk("fetch_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("fetch_i_rdata",  bus.i_rdata,       32'h0010_0093);
        chk("fetch_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        // Data write to address 0 (low address bits set to show they are ignored).
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0003;
        bus.d_wdata = 32'h0000_01FE;
        @(negedge clk);
        chk("wr_d_gnt",   32'(bus.d_gnt),  32'd1);
        chk("wr_m_en",    32'(bus.m_en),   32'd1);
        chk("wr_m_we",    32'(bus.m_we),   32'd1);
        chk("wr_m_addr",  32'(bus.m_addr), 32'd0);
        chk("wr_m_wdata", bus.m_wdata,     32'h0000_01FE);
        tick();
        idleReqs();
        @(negedge clk);
        chk("wr_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("wr_i_rvalid", 32'(bus.i_rvalid), 32'd0);

        // Write 0xFF to 0x10, then read it back from the instruction port.
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        bus.d_wdata = 32'h0000_00FF;
        @(negedge clk);
        chk("wrd_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        idleReqs();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0010;
        @(negedge clk);
        chk("wrd_i_gnt",    32'(bus.i_gnt),  32'd1);
        chk("wrd_m_addr",   32'(bus.m_addr), 32'd4);
        tick();
        idleReqs();
        @(negedge clk);
        chk("wrd_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("wrd_i_rdata",  bus.i_rdata,       32'h0000_00FF);

        // Withdrawal: make DATA the last owner, then a tie that I wins; D drops its request.
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'h0000_0077;
        @(negedge clk);
        chk("wd_pre_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_0000;
        bus.d_addr  = 32'h0000_0024;
        bus.d_wdata = 32'h0000_DEAD;
        @(negedge clk);
        chk("wd_i_gnt",   32'(bus.i_gnt),  32'd1);
        chk("wd_d_gnt",   32'(bus.d_gnt),  32'd0);
        chk("wd_m_we",    32'(bus.m_we),   32'd0);
        chk("wd_m_wdata", bus.m_wdata,     32'h0000_DEAD);
        tick();
        idleReqs();
        @(negedge clk);
        chk("wd_after_d_gnt",  32'(bus.d_gnt),    32'd0);
        chk("wd_after_m_en",   32'(bus.m_en),     32'd0);
        chk("wd_i_rvalid",     32'(bus.i_rvalid), 32'd1);
        chk("wd_i_rdata",      bus.i_rdata,       32'h0000_01FE);
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0024;
        @(negedge clk);
        chk("wd_chk_i_gnt", 32'(bus.i_gnt), 32'd1);
        tick();
        idleReqs();
        @(negedge clk);
        chk("wd_no_write_rdata", bus.i_rdata, 32'h0000_0000);

        // Reset arrives the cycle after a data read is granted.
        tick();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0010;
        @(negedge clk);
        chk("rmr_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        reset       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_0004;
        bus.d_addr  = 32'h0000_0008;
        bus.d_wdata = 32'h0000_5555;
        @(negedge clk);
        chkAllQuiet("rmr1");
        tick();
        @(negedge clk);
        chkAllQuiet("rmr2");
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rmr_rel_i_gnt",    32'(bus.i_gnt),    32'd1);
        chk("rmr_rel_d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("rmr_rel_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        tick();
        idleReqs();
        @(negedge clk);
        chk("rmr_post_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("rmr_post_i_rdata",  bus.i_rdata,       32'h0010_0093);
        chk("rmr_post_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
